ram_bus_frontend: RTL

Upstream stage of the FastRAM DRAM sequencer. It synchronises the asynchronous 68000 bus strobes into the CLK domain and decodes each bus cycle against the autoconfig bank map. It latches the row/column address and issues exactly one access request per hit cycle. It also owns the CAS-before-RAS refresh scheduler and arbitrates refresh against bus accesses, so the downstream sequencer only executes commands.

---
 rtl/ram_pkg.sv | 23 ++
 rtl/sync_flop.sv | 21 ++
 rtl/ram_bus_frontend.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared types and constants for the FastRAM bus frontend.
package ram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT_DS, ST_ACCESS, ST_HOLD, ST_MISS, ST_REFRESH
  } state_t;

  localparam logic [3:0] BANK_BASE = 4'h2;
  localparam logic [3:0] BANK_LAST = 4'h9;
  localparam int ROW_W = 12;
  localparam int COL_W = 10;
  localparam int REFRESH_INTERVAL_DEF = 108;
  localparam int MAX_DEBT_DEF = 7;

  // Bank 2..9 maps onto ADDR_MATCH[0..7].
  function automatic logic bank_hit(input logic cfg, input logic [3:0] bank,
                                    input logic [7:0] match);
    logic [3:0] idx;
    idx = bank - BANK_BASE;
    return cfg && (bank >= BANK_BASE) && (bank <= BANK_LAST) && match[idx[2:0]];
  endfunction

endpackage

// File: rtl/sync_flop.sv
// Multi-stage synchroniser for a bundle of async active-low strobes; resets inactive (1).
module sync_flop #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] stg;

  always_ff @(posedge CLK) begin
    if (!RESETn) stg <= '1;
    else         stg <= {stg[DEPTH-2:0], d};
  end

  assign q = stg[DEPTH-1];

endmodule

// File: rtl/ram_bus_frontend.sv
// 68000 bus frontend: strobe sync, bank decode, one request per hit cycle, refresh scheduling.
module ram_bus_frontend
  import ram_pkg::*;
#(
  parameter int SYNC_STAGES      = 2,
  parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF,
  parameter int MAX_DEBT         = MAX_DEBT_DEF
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             ASn,
  input  logic             UDSn,
  input  logic             LDSn,
  input  logic             RWn,
  input  logic [23:1]      ADDR,
  input  logic [7:0]       ADDR_MATCH,
  input  logic             CONFIGURED,
  input  logic             MEM_ACK,
  output logic             REQ_VALID,
  output logic             REQ_WRITE,
  output logic             REQ_UPPER,
  output logic             REQ_LOWER,
  output logic [ROW_W-1:0] REQ_ROW,
  output logic [COL_W-1:0] REQ_COL,
  output logic             REFRESH_REQ,
  output logic             REFRESH_OVERDUE,
  output logic             CYCLE_END,
  output logic             ABORT
);

  localparam int CNT_W = $clog2(REFRESH_INTERVAL);
  localparam logic [2:0] DEBT_MAX = 3'(MAX_DEBT);

  state_t           state;
  logic [3:0]       strb_s;
  logic             asn_s, udsn_s, ldsn_s, rwn_s;
  logic             as_s, as_prev, as_fall, fall_pend, go_fall;
  logic             ds_any, hit, dec_wr, wr_q, tick, ref_ack;
  logic [23:1]      addr_q, dec_addr;
  logic [CNT_W-1:0] ivl_cnt;
  logic [2:0]       debt;

  sync_flop #(.WIDTH(4), .DEPTH(SYNC_STAGES)) u_sync (
    .CLK    (CLK),
    .RESETn (RESETn),
    .d      ({ASn, UDSn, LDSn, RWn}),
    .q      (strb_s)
  );

  assign {asn_s, udsn_s, ldsn_s, rwn_s} = strb_s;
  assign as_s     = ~asn_s;
  assign ds_any   = ~udsn_s | ~ldsn_s;
  assign as_fall  = as_s & ~as_prev;
  // A fall seen during refresh is replayed from the captured address once back in IDLE.
  assign go_fall  = as_fall | (fall_pend & as_s);
  assign dec_addr = as_fall ? ADDR : addr_q;
  assign dec_wr   = as_fall ? ~rwn_s : wr_q;
  assign hit      = bank_hit(CONFIGURED, dec_addr[23:20], ADDR_MATCH);
  assign tick     = (ivl_cnt == CNT_W'(REFRESH_INTERVAL - 1));
  assign ref_ack  = (state == ST_REFRESH) && MEM_ACK;
  assign REFRESH_OVERDUE = (debt == DEBT_MAX);

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state       <= ST_IDLE;
      as_prev     <= 1'b0;
      fall_pend   <= 1'b0;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      ivl_cnt     <= '0;
      debt        <= '0;
      REQ_VALID   <= 1'b0;
      REQ_WRITE   <= 1'b0;
      REQ_UPPER   <= 1'b0;
      REQ_LOWER   <= 1'b0;
      REQ_ROW     <= '0;
      REQ_COL     <= '0;
      REFRESH_REQ <= 1'b0;
      CYCLE_END   <= 1'b0;
      ABORT       <= 1'b0;
    end else begin
      as_prev   <= as_s;
      CYCLE_END <= 1'b0;
      ABORT     <= 1'b0;
      ivl_cnt   <= tick ? '0 : ivl_cnt + CNT_W'(1);

      if (tick && !ref_ack) begin
        if (debt != DEBT_MAX) debt <= debt + 3'd1;
      end else if (ref_ack && !tick) begin
        debt <= debt - 3'd1;
      end

      if (as_fall) begin
        addr_q <= ADDR;
        wr_q   <= ~rwn_s;
      end

      if (!as_s)                                fall_pend <= 1'b0;
      else if (as_fall && state == ST_REFRESH)  fall_pend <= 1'b1;
      else if (state == ST_IDLE)                fall_pend <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (go_fall) begin
            if (hit) begin
              REQ_ROW   <= dec_addr[22:11];
              REQ_COL   <= dec_addr[10:1];
              REQ_WRITE <= dec_wr;
              // Strobes already valid (typical read): issue straight away.
              if (ds_any) begin
                state     <= ST_ACCESS;
                REQ_VALID <= 1'b1;
                REQ_UPPER <= ~udsn_s;
                REQ_LOWER <= ~ldsn_s;
              end else begin
                state <= ST_WAIT_DS;
              end
            end else begin
              state <= ST_MISS;
            end
          end else if (debt != 3'd0 && !as_s) begin
            state       <= ST_REFRESH;
            REFRESH_REQ <= 1'b1;
          end
        end
        ST_WAIT_DS: begin
          if (!as_s) begin
            state <= ST_IDLE;
            ABORT <= 1'b1;
          end else if (ds_any) begin
            state     <= ST_ACCESS;
            REQ_VALID <= 1'b1;
            REQ_UPPER <= ~udsn_s;
            REQ_LOWER <= ~ldsn_s;
          end
        end
        ST_ACCESS: begin
          if (MEM_ACK) begin
            REQ_VALID <= 1'b0;
            if (!as_s) begin
              state     <= ST_IDLE;
              CYCLE_END <= 1'b1;
            end else begin
              state <= ST_HOLD;
            end
          end else if (!as_s) begin
            REQ_VALID <= 1'b0;
            state     <= ST_IDLE;
            ABORT     <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (!as_s) begin
            state     <= ST_IDLE;
            CYCLE_END <= 1'b1;
          end
        end
        ST_MISS: begin
          if (!as_s) state <= ST_IDLE;
        end
        ST_REFRESH: begin
          if (MEM_ACK) begin
            REFRESH_REQ <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
